// File: rtl/sump_cmd_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the SUMP command
// parser and the logIP core.
interface sump_cmd_parser_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  cmd_opcode_o;
    logic [31:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        drop_o;
    logic        timeout_o;

    modport master (
        output rx_data_i, rx_valid_i, cmd_ready_i,
        input  cmd_opcode_o, cmd_data_o, cmd_valid_o, drop_o, timeout_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, cmd_ready_i,
        output cmd_opcode_o, cmd_data_o, cmd_valid_o, drop_o, timeout_o
    );
endinterface

// File: rtl/sump_cmd_parser.sv
// Assembles SUMP short (1-byte) and long (opcode + 32-bit LE argument) commands
// from UART byte strobes and hands them to the core over valid/ready.
module sump_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sump_cmd_parser_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Last idle cycle before the abort; a byte arriving here still wins.
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t          state_r;
    logic [7:0]      opcode_r;
    logic [31:0]     data_r;
    logic [1:0]      idx_r;
    logic [CW-1:0]   cnt_r;
    logic            valid_r;
    logic            drop_r;
    logic            timeout_r;
    logic            start_s;

    // A new opcode is taken in IDLE, or in PEND when the handshake frees the slot.
    always_comb begin
        start_s = 1'b0;
        if (bus.rx_valid_i && ((state_r == ST_IDLE) ||
                               ((state_r == ST_PEND) && bus.cmd_ready_i))) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Command FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            opcode_r  <= 8'h00;
            data_r    <= 32'h0000_0000;
            idx_r     <= 2'd0;
            cnt_r     <= '0;
            valid_r   <= 1'b0;
            drop_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            drop_r    <= 1'b0;
            timeout_r <= 1'b0;
            if (start_s) begin
                opcode_r <= bus.rx_data_i;
                data_r   <= 32'h0000_0000;
                idx_r    <= 2'd0;
                cnt_r    <= '0;
                if (bus.rx_data_i[7]) begin
                    state_r <= ST_ARG;
                    valid_r <= 1'b0;
                end else begin
                    state_r <= ST_PEND;
                    valid_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        valid_r <= 1'b0;
                    end
                    ST_ARG: begin
                        if (bus.rx_valid_i) begin
                            data_r[{idx_r, 3'b000} +: 8] <= bus.rx_data_i;
                            idx_r <= idx_r + 2'd1;
                            cnt_r <= '0;
                            if (idx_r == 2'd3) begin
                                state_r <= ST_PEND;
                                valid_r <= 1'b1;
                            end else begin
                                state_r <= ST_ARG;
                            end
                        end else if (cnt_r >= TERM) begin
                            state_r   <= ST_IDLE;
                            cnt_r     <= '0;
                            timeout_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                    ST_PEND: begin
                        if (bus.cmd_ready_i) begin
                            state_r <= ST_IDLE;
                            valid_r <= 1'b0;
                        end else if (bus.rx_valid_i) begin
                            drop_r <= 1'b1;
                        end else begin
                            valid_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        idx_r   <= 2'd0;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_opcode_o = opcode_r;
    assign bus.cmd_data_o   = data_r;
    assign bus.cmd_valid_o  = valid_r;
    assign bus.drop_o       = drop_r;
    assign bus.timeout_o    = timeout_r;
endmodule

// File: doc/sump_cmd_parser.md
# sump_cmd_parser

Command sequencer between `tuart_rx` and the logIP core. It consumes the byte strobes from the UART receiver and assembles SUMP commands: short 1-byte commands and long 5-byte commands (opcode plus 32-bit little-endian argument). Each completed command is presented to the core over a valid/ready handshake. An inter-byte timeout discards partially received long commands.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle clock cycles allowed between bytes of a long command before it is aborted. Must be ≥ 1.
- `clk_i`  in  1  system clock; everything is sampled on the rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `rx_data_i`  in  8  received byte from `tuart_rx`.
- `rx_valid_i`  in  1  one-cycle strobe; `rx_data_i` is valid in that cycle.
- `cmd_opcode_o`  out  8  opcode of the pending command.
- `cmd_data_o`  out  32  argument of the pending command; 0 for short commands.
- `cmd_valid_o`  out  1  a command is pending; held until accepted.
- `cmd_ready_i`  in  1  the core accepts the command in any cycle where `cmd_valid_o & cmd_ready_i`.
- `drop_o`  out  1  one-cycle pulse: a byte was discarded because a command was pending.
- `timeout_o`  out  1  one-cycle pulse: a partial long command was aborted.

Reset is synchronous and active-high; the design uses a single clock.

## Operation
- States: IDLE, ARG, PEND.
- IDLE:
  - On `rx_valid_i`, latch `rx_data_i` into the opcode register.
  - If bit 7 = 0 (short command): clear the data register and go to PEND.
  - If bit 7 = 1 (long command): clear the byte index and the data register, clear the timeout counter, go to ARG.
- ARG:
  - On `rx_valid_i`, write the byte to `data[8*idx+7 : 8*idx]`, increment idx (2 bits), and clear the timeout counter.
  - When the byte with idx = 3 arrives, go to PEND.
  - Without a byte, the timeout counter increments. When it reaches `TIMEOUT_CYCLES`, go to IDLE and pulse `timeout_o`. The opcode and data registers are not cleared, but no command is issued.
  - If a byte and the timeout terminal count coincide, the byte wins: it is stored and the counter clears.
- PEND:
  - `cmd_valid_o` = 1. `cmd_opcode_o` and `cmd_data_o` stay stable until the handshake.
  - On the handshake without `rx_valid_i`: go to IDLE.
  - On `rx_valid_i` without the handshake: discard the byte, pulse `drop_o`, stay in PEND.
  - On the handshake and `rx_valid_i` in the same cycle: accept the command and process the byte exactly as in IDLE (next state PEND or ARG). No drop.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps. It is active only in ARG.
- Byte-index wrap 3→0 occurs only on the transition to PEND.

## Timing
- Reset values: `cmd_valid_o`=0, `cmd_opcode_o`=0x00, `cmd_data_o`=0, `drop_o`=0, `timeout_o`=0. State = IDLE, idx = 0, counter = 0.
- Reset asserted mid-command or while PEND: the next edge returns to the reset state. The partial or pending command is lost, with no `drop_o` or `timeout_o` pulse.
- Latency:
  - Short command: `cmd_valid_o` rises in the cycle after the opcode strobe.
  - Long command: `cmd_valid_o` rises in the cycle after the 4th argument strobe.
- `cmd_valid_o` falls in the cycle after the handshake, unless a new short command was started in the handshake cycle. In that case it stays high with the new contents.
- `drop_o` and `timeout_o` are registered and occur in the cycle after their cause. They are mutually exclusive.
- Back-to-back `rx_valid_i` on consecutive cycles must be accepted in IDLE and ARG.
- Timeout: with the last byte strobe at cycle t and no further strobes, `timeout_o` is high in cycle t + `TIMEOUT_CYCLES` + 1.

## Test plan
- Short command, ready tied high: byte 0x00 → `cmd_valid_o` high for exactly 1 cycle, opcode 0x00, data 0x00000000. Then byte 0x02 → opcode 0x02.
- Long command: bytes 0x80, 0x78, 0x56, 0x34, 0x12 with ready held low → valid holds with opcode 0x80, data 0x12345678. After 3 idle cycles, ready goes high → valid drops in the next cycle.
- Drop and simultaneity:
  - While PEND, with ready low, byte 0x11 arrives → `drop_o` for 1 cycle and data unchanged.
  - Then ready and byte 0x01 arrive in the same cycle → old command accepted, a new pending command with opcode 0x01, no drop.
- Timeout, with `TIMEOUT_CYCLES`=8: bytes 0xC0, 0xAA, then silence → `timeout_o` 9 cycles after 0xAA and no `cmd_valid_o`. Sending 0x05 afterwards → short command 0x05.
- Timeout race, with `TIMEOUT_CYCLES`=8: 0xC0, then argument bytes each arriving exactly at the terminal count → no timeout, command 0xC0 issued with the correct data.
- Reset mid-ARG after 2 argument bytes → all outputs 0 on the next cycle. A fresh 0x80 plus 4 bytes then completes normally.
